// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packer.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } frame_state_t;

  localparam int unsigned FRAME_LEN_BASE    = 1;
  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_fifo.sv
// Synchronous FIFO with occupancy count; accepts a push when full if a pop happens in the same cycle.
module uart_frame_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_frame_packer.sv
// Buffers words and serialises each as SYNC_BYTE + data bytes (LSB first) onto a UART TX byte handshake.
// Define UART_FRAME_CHECKSUM_EN to append an XOR-of-data-bytes checksum to every frame.
module uart_frame_packer
  import uart_frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst,
  input  logic                        i_Word_Valid,
  input  logic [8*DATA_BYTES-1:0]     i_Word,
  output logic                        o_Word_Ready,
  output logic                        o_TX_DV,
  output logic [7:0]                  o_TX_Byte,
  input  logic                        i_TX_Active,
  input  logic                        i_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Busy,
  output logic [15:0]                 o_Frames_Sent
);

  localparam int unsigned WORD_W = 8*DATA_BYTES;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + DATA_BYTES + 1;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + DATA_BYTES;
`endif
  localparam int unsigned      IDX_W         = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BYTES);

  frame_state_t         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [15:0]          frames_q, frames_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic                        push, pop, byte_done;
  logic [WORD_W-1:0]           fifo_rdata;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_frame_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst   (i_Rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_Word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    frames_d  = frames_q;
    byte_done = 1'b0;
    pop       = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          idx_d   = '0;
          state_d = ISSUE;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d  = '0;
          for (int unsigned b = 0; b < DATA_BYTES; b++) csum_d = csum_d ^ fifo_rdata[8*b +: 8];
`endif
        end
      end
      ISSUE: begin
        tx_dv_d = 1'b1;
        state_d = WAIT_START;
        if (idx_q == '0) begin
          tx_byte_d = SYNC_BYTE;
        end else if (idx_q <= LAST_DATA_IDX) begin
          tx_byte_d = shift_q[7:0];
          shift_d   = shift_q >> 8;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        else begin
          tx_byte_d = csum_q;
        end
`endif
      end
      // A done seen before active completes the byte directly, so it is never lost.
      WAIT_START: begin
        if (i_TX_Done)        byte_done = 1'b1;
        else if (i_TX_Active) state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_TX_Done) byte_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        frames_d = frames_q + 1'b1;
        state_d  = IDLE;
      end else begin
        state_d  = ISSUE;
      end
    end

    o_Word_Ready = ~fifo_full | pop;
    push         = i_Word_Valid & o_Word_Ready;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      frames_q  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      frames_q  <= frames_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_TX_DV       = tx_dv_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_Frames_Sent = frames_q;
  assign o_Fifo_Count  = fifo_count;
  assign o_Busy        = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_frame_packer.sv
// Randomised self-checking bench for uart_frame_packer with an in-bench transmitter and byte-queue reference.
module tb_uart_frame_packer;

  localparam int unsigned DATA_BYTES = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [7:0]  SYNC       = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN  = DATA_BYTES + 2;
`else
  localparam int unsigned FRAME_LEN  = DATA_BYTES + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] word = '0;
  logic        ready, dv;
  logic [7:0]  tx_byte;
  logic        active = 1'b0;
  logic        done = 1'b0;
  logic [3:0]  count;
  logic        busy;
  logic [15:0] frames;

  always #5 clk = ~clk;

  uart_frame_packer #(
    .DATA_BYTES (DATA_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_BYTE  (SYNC)
  ) dut (
    .i_Clock       (clk),
    .i_Rst         (rst),
    .i_Word_Valid  (valid),
    .i_Word        (word),
    .o_Word_Ready  (ready),
    .o_TX_DV       (dv),
    .o_TX_Byte     (tx_byte),
    .i_TX_Active   (active),
    .i_TX_Done     (done),
    .o_Fifo_Count  (count),
    .o_Busy        (busy),
    .o_Frames_Sent (frames)
  );

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  dv_log[$];
  logic [7:0]  exp_log[$];
  bit          tx_stall = 0, tx_busy = 0, tx_pend = 0, frame_done_dly = 0;
  int          tx_cnt = 0, done_in_frame = 0, dv_count = 0, first_dv_cyc = -1;
  logic [7:0]  held_byte = '0;
  logic [15:0] exp_frames = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: sync, data bytes LSB first, optional XOR checksum.
  task automatic enqueue_frame(input logic [31:0] w);
    exp_q.push_back(SYNC);
    for (int i = 0; i < DATA_BYTES; i++) exp_q.push_back(w[8*i +: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = '0;
      for (int i = 0; i < DATA_BYTES; i++) cs = cs ^ w[8*i +: 8];
      exp_q.push_back(cs);
    end
`endif
  endtask

  // One clock: transmitter model plus every-cycle comparison against the reference.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      tx_busy = 0; tx_pend = 0; active = 1'b0; done = 1'b0;
      done_in_frame = 0; frame_done_dly = 0; exp_frames = '0;
      chk("dv_in_reset", dv, 0);
    end else begin
      if (frame_done_dly) begin exp_frames++; frame_done_dly = 0; end
      if ((tx_busy || tx_pend) && !dv) chk("tx_byte_held", tx_byte, held_byte);
      if (tx_busy) begin
        tx_cnt++;
        if (tx_cnt == 11) begin
          active = 1'b0; done = 1'b1;
          done_in_frame++;
          if (done_in_frame == FRAME_LEN) begin done_in_frame = 0; frame_done_dly = 1; end
        end else if (tx_cnt == 12) begin
          done = 1'b0; tx_busy = 0;
        end
      end else if (tx_pend && !tx_stall) begin
        tx_pend = 0; tx_busy = 1; tx_cnt = 1; active = 1'b1;
      end
      if (dv) begin
        dv_count++;
        dv_log.push_back(tx_byte);
        if (first_dv_cyc < 0) first_dv_cyc = cyc;
        chk("dv_single_pulse", {31'd0, tx_pend | tx_busy}, 0);
        if (exp_q.size() == 0) chk("dv_unexpected", 1, 0);
        else chk("tx_byte", tx_byte, exp_q.pop_front());
        held_byte = tx_byte;
        tx_pend = 1;
      end
    end
    chk("frames_sent", frames, exp_frames);
  endtask

  task automatic push(input logic [31:0] w, output bit acc);
    valid = 1'b1; word = w;
    acc = ready && !rst;
    if (acc) enqueue_frame(w);
    tick();
    valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || tx_busy || tx_pend || frame_done_dly || exp_q.size() != 0) && n < budget) begin
      tick(); n++;
    end
    chk("drain_in_time", {31'd0, n < budget}, 1);
    chk("all_bytes_sent", exp_q.size(), 0);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, dv_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < dv_log.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), dv_log[i], exp_log[i]);
  endtask

  initial begin
    bit acc;
    int p, base, n;
    logic [31:0] w;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", ready, 1);
    chk("rst_dv", dv, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames, 0);
    rst = 1'b0;
    tick();

    // Single frame, literal byte sequence and latency
    dv_log.delete(); first_dv_cyc = -1; base = dv_count;
    p = cyc;
    push(32'h44332211, acc);
    drain(500);
`ifdef UART_FRAME_CHECKSUM_EN
    exp_log = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
    exp_log = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    chk_log("frame1");
    chk("frame1_dv_pulses", dv_count - base, FRAME_LEN);
    chk("frame1_latency", first_dv_cyc - p - 1, 2);
    chk("frame1_frames", frames, 1);

    // Fill while transmitter stalled: one word held by the framer, eight buffered
    tx_stall = 1;
    for (int i = 0; i < 10; i++) push($urandom, acc);
    chk("fill_last_refused", {31'd0, acc}, 0);
    tick();
    chk("fill_count", count, FIFO_DEPTH);
    chk("fill_ready", ready, 0);
    chk("fill_busy", busy, 1);
    tx_stall = 0;
    drain(3000);
    chk("fill_frames", frames, 10);

    // Push and pop in the same cycle while full
    tx_stall = 1;
    n = 0;
    do begin push($urandom, acc); n++; end while ((count != FIFO_DEPTH || ready) && n < 20);
    chk("full_again", count, FIFO_DEPTH);
    tx_stall = 0;
    n = 0;
    acc = 0;
    while (!acc && n < 300) begin push(32'hCAFE0000 + n, acc); n++; end
    chk("simul_accepted", {31'd0, acc}, 1);
    chk("simul_count", count, FIFO_DEPTH);
    drain(3000);

    // Reset during the third byte of a frame
    base = dv_count;
    push(32'hDEADBEEF, acc);
    n = 0;
    while (dv_count - base < 3 && n < 200) begin tick(); n++; end
    chk("third_byte_reached", dv_count - base, 3);
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("postrst_count", count, 0);
    chk("postrst_frames", frames, 0);
    base = dv_count;
    repeat (40) tick();
    chk("postrst_no_dv", dv_count - base, 0);
    dv_log.delete();
    push(32'h87654321, acc);
    drain(500);
`ifdef UART_FRAME_CHECKSUM_EN
    exp_log = '{8'hA5, 8'h21, 8'h43, 8'h65, 8'h87, 8'h80};
`else
    exp_log = '{8'hA5, 8'h21, 8'h43, 8'h65, 8'h87};
`endif
    chk_log("postrst");
    chk("postrst_frames1", frames, 1);

`ifdef UART_FRAME_CHECKSUM_EN
    dv_log.delete();
    push(32'h0F0F00FF, acc);
    drain(500);
    exp_log = '{8'hA5, 8'hFF, 8'h00, 8'h0F, 8'h0F, 8'hFF};
    chk_log("checksum");
`endif

    // Randomised traffic with intermittent transmitter stalls
    for (int i = 0; i < 120; i++) begin
      tx_stall = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        push(w, acc);
      end else begin
        tick();
      end
    end
    tx_stall = 0;
    drain(5000);

    // Frame counter wrap
    force dut.frames_q = 16'hFFFF;
    exp_frames = 16'hFFFF;
    repeat (2) tick();
    release dut.frames_q;
    tick();
    chk("wrap_preload", frames, 16'hFFFF);
    push($urandom, acc);
    drain(500);
    chk("wrap_to_zero", frames, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
